// File: rtl/tetris_key_pkg.sv
// rtl/tetris_key_pkg.sv - shared key indices and repeat FSM state type
// Purpose: key channel index constants for the game keypad and the
//          per-key auto-repeat state encoding.
// Ports:   none (package)
package tetris_key_pkg;

    localparam int KEY_UP        = 0;
    localparam int KEY_LEFT      = 1;
    localparam int KEY_RIGHT     = 2;
    localparam int KEY_DOWN      = 3;
    localparam int NUM_GAME_KEYS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/key_chan.sv
// rtl/key_chan.sv - one key channel: synchroniser, debounce, hold-to-repeat
// Purpose: turns one raw button into a debounced level plus registered
//          press/release pulses, with optional auto-repeat press pulses.
// Ports:   clk, clr (async active-low reset)
//          i_key      raw button input
//          i_rpt_en   auto-repeat enable
//          i_lock     suppress press/release pulses
//          o_level    debounced pressed state
//          o_press    registered press pulse (edge or repeat)
//          o_release  registered release pulse
//          o_press_d  next-cycle value of o_press (for the shared any_press flop)
module key_chan
    import tetris_key_pkg::*;
#(
    parameter bit ACTIVE_HIGH = 1'b1,
    parameter int DEB_CYCLES  = 1000000,
    parameter int RPT_DELAY   = 25000000,
    parameter int RPT_PERIOD  = 5000000
) (
    input  logic clk,
    input  logic clr,
    input  logic i_key,
    input  logic i_rpt_en,
    input  logic i_lock,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_press_d
);

    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(RPT_PERIOD - 1);
    localparam logic             REL_LVL  = ~ACTIVE_HIGH;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic [DEB_W-1:0] r_deb_cnt;
    rpt_state_e       r_state;
    rpt_state_e       w_state_nxt;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic [RPT_W-1:0] w_rpt_cnt_nxt;

    logic w_s;
    logic w_differ;
    logic w_accept;
    logic w_rise;
    logic w_fall;
    logic w_held_nxt;
    logic w_fire;
    logic w_press_nxt;

    assign w_s         = ACTIVE_HIGH ? r_sync2 : ~r_sync2;
    assign w_differ    = (w_s != r_level);
    // Accept on the cycle the stable-run count would reach DEB_CYCLES.
    assign w_accept    = w_differ && (r_deb_cnt == DEB_LAST);
    assign w_rise      = w_accept && !r_level;
    assign w_fall      = w_accept && r_level;
    // Level as it will be after this edge.
    assign w_held_nxt  = w_rise || (r_level && !w_fall);
    assign w_press_nxt = (w_rise && !i_lock) || w_fire;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sync1   <= REL_LVL;
            r_sync2   <= REL_LVL;
            r_level   <= 1'b0;
            r_deb_cnt <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_key;
            r_sync2   <= r_sync1;
            if (!w_differ) begin
                r_deb_cnt <= '0;
            end else if (w_accept) begin
                r_deb_cnt <= '0;
                r_level   <= ~r_level;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
            r_press   <= w_press_nxt;
            r_release <= w_fall && !i_lock;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= IDLE;
            r_rpt_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
        end
    end

    // Release, disable or lock all abort repeating; an abort also masks a
    // repeat falling due on the same cycle as an accepted release.
    always_comb begin
        w_state_nxt   = r_state;
        w_rpt_cnt_nxt = r_rpt_cnt;
        w_fire        = 1'b0;
        if (w_fall || !i_rpt_en || i_lock) begin
            w_state_nxt   = IDLE;
            w_rpt_cnt_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Covers both a fresh press and re-enable while held.
                    if (w_held_nxt) begin
                        w_state_nxt   = DELAY;
                        w_rpt_cnt_nxt = '0;
                    end
                end
                DELAY: begin
                    if (r_rpt_cnt == DLY_LAST) begin
                        w_fire        = 1'b1;
                        w_state_nxt   = REPEAT;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (r_rpt_cnt == PER_LAST) begin
                        w_fire        = 1'b1;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_rpt_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_press_d = w_press_nxt;

endmodule

// File: rtl/key_input_ctrl.sv
// rtl/key_input_ctrl.sv - multi-key debouncer with press/release/repeat pulses
// Purpose: NUM_KEYS independent key channels feeding the game control FSM.
// Ports:   clk, clr (async active-low reset)
//          key_in[NUM_KEYS]       raw buttons
//          rpt_en[NUM_KEYS]       per-key auto-repeat enable
//          lock                   suppress all press/release pulses
//          key_level[NUM_KEYS]    debounced pressed state
//          key_press[NUM_KEYS]    press / repeat pulses
//          key_release[NUM_KEYS]  release pulses
//          any_press              OR of key_press, registered alongside it
module key_input_ctrl
    import tetris_key_pkg::*;
#(
    parameter int NUM_KEYS    = NUM_GAME_KEYS,
    parameter bit ACTIVE_HIGH = 1'b1,
    parameter int DEB_CYCLES  = 1000000,
    parameter int RPT_DELAY   = 25000000,
    parameter int RPT_PERIOD  = 5000000
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [NUM_KEYS-1:0] rpt_en,
    input  logic                lock,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_press
);

    logic [NUM_KEYS-1:0] w_press_nxt;
    logic                r_any_press;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
        key_chan #(
            .ACTIVE_HIGH (ACTIVE_HIGH),
            .DEB_CYCLES  (DEB_CYCLES),
            .RPT_DELAY   (RPT_DELAY),
            .RPT_PERIOD  (RPT_PERIOD)
        ) u_chan (
            .clk       (clk),
            .clr       (clr),
            .i_key     (key_in[gi]),
            .i_rpt_en  (rpt_en[gi]),
            .i_lock    (lock),
            .o_level   (key_level[gi]),
            .o_press   (key_press[gi]),
            .o_release (key_release[gi]),
            .o_press_d (w_press_nxt[gi])
        );
    end

    // Built from the channels' next-press values so it lines up with key_press.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_any_press <= 1'b0;
        end else begin
            r_any_press <= |w_press_nxt;
        end
    end

    assign any_press = r_any_press;

endmodule

// File: tb/tb_key_input_ctrl.sv
// tb/tb_key_input_ctrl.sv - self-checking bench for key_input_ctrl
module tb_key_input_ctrl;
    import tetris_key_pkg::*;

    localparam int NK  = NUM_GAME_KEYS;
    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;

    logic          clk    = 1'b0;
    logic          clr    = 1'b0;
    logic [NK-1:0] key_in = '0;
    logic [NK-1:0] rpt_en = '0;
    logic          lock   = 1'b0;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          any_press;

    int checks   = 0;
    int failures = 0;

    key_input_ctrl #(
        .NUM_KEYS    (NK),
        .ACTIVE_HIGH (1'b1),
        .DEB_CYCLES  (DEB),
        .RPT_DELAY   (DLY),
        .RPT_PERIOD  (PER)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .key_in      (key_in),
        .rpt_en      (rpt_en),
        .lock        (lock),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .any_press   (any_press)
    );

    always #5 clk = ~clk;

    // Reference model: key_in delayed two cycles, a level accepted after DEB
    // consecutive differing cycles, and repeats scheduled as absolute due times.
    bit [NK-1:0] m_p1   = '0;
    bit [NK-1:0] m_p2   = '0;
    bit [NK-1:0] m_lvl  = '0;
    bit [NK-1:0] m_prs  = '0;
    bit [NK-1:0] m_rel  = '0;
    bit          m_any  = 1'b0;
    int          m_run   [NK];
    bit          m_armed [NK];
    longint      m_due   [NK];
    longint      m_cyc  = 0;

    initial begin
        for (int i = 0; i < NK; i++) begin
            m_run[i] = 0; m_armed[i] = 0; m_due[i] = 0;
        end
        forever begin
            @(posedge clk or negedge clr);
            if (!clr) begin
                m_p1 = '0; m_p2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
                m_any = 1'b0; m_cyc = 0;
                for (int i = 0; i < NK; i++) begin
                    m_run[i] = 0; m_armed[i] = 0; m_due[i] = 0;
                end
            end else begin
                m_cyc++;
                for (int i = 0; i < NK; i++) begin
                    bit s, rise, fall, p;
                    s = m_p2[i];
                    m_p2[i] = m_p1[i];
                    m_p1[i] = key_in[i];
                    rise = 0; fall = 0;
                    if (s != m_lvl[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DEB) begin
                            m_lvl[i] = s; m_run[i] = 0;
                            rise = s; fall = !s;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                    p = rise && !lock;
                    m_rel[i] = fall && !lock;
                    if (fall || !rpt_en[i] || lock) begin
                        m_armed[i] = 0;
                    end else if (m_armed[i]) begin
                        if (m_cyc == m_due[i]) begin
                            p = 1;
                            m_due[i] = m_cyc + PER;
                        end
                    end else if (m_lvl[i]) begin
                        m_armed[i] = 1;
                        m_due[i] = m_cyc + DLY;
                    end
                    m_prs[i] = p;
                end
                m_any = |m_prs;
            end
        end
    end

    task automatic settle();
        key_in = '0; rpt_en = '0; lock = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        clr = 1'b0; key_in = '1;
        repeat (3) @(negedge clk);
        checks++;
        if ({key_level, key_press, key_release, any_press} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {key_level, key_press, key_release, any_press});
        end
        clr = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 5) begin
                checks++;
                if (key_level !== 4'h0) begin
                    failures++; $display("FAIL reset_early_level got=%h exp=0", key_level);
                end
            end
            if (k == 6) begin
                checks++;
                if ({key_level, key_press, any_press} !== {4'hf, 4'hf, 1'b1}) begin
                    failures++;
                    $display("FAIL reset_held_press got=%h/%h/%b exp=f/f/1", key_level, key_press, any_press);
                end
            end
            if (k == 7) begin
                checks++;
                if ({key_level, key_press} !== {4'hf, 4'h0}) begin
                    failures++; $display("FAIL reset_press_width got=%h/%h exp=f/0", key_level, key_press);
                end
            end
        end
        key_in = '0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) begin
                checks++;
                if ({key_level, key_release, key_press} !== {4'h0, 4'hf, 4'h0}) begin
                    failures++;
                    $display("FAIL reset_release got=%h/%h/%h exp=0/f/0", key_level, key_release, key_press);
                end
            end
        end
        settle();
    endtask

    task automatic test_glitch();
        logic [3*NK-1:0] acc;
        acc = '0;
        key_in[KEY_LEFT] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 3) key_in[KEY_LEFT] = 1'b0;
            acc |= {key_level, key_press, key_release};
        end
        checks++;
        if (acc !== '0) begin
            failures++; $display("FAIL glitch_ignored got=%h exp=0", acc);
        end
        key_in[KEY_LEFT] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 5) begin
                checks++;
                if (key_level[KEY_LEFT] !== 1'b0) begin
                    failures++; $display("FAIL hold_early got=%b exp=0", key_level[KEY_LEFT]);
                end
            end
            if (k == 6) begin
                checks++;
                if ({key_level, key_press} !== {4'h2, 4'h2}) begin
                    failures++; $display("FAIL hold_accept got=%h/%h exp=2/2", key_level, key_press);
                end
            end
            if (k == 7) begin
                checks++;
                if (key_press !== 4'h0) begin
                    failures++; $display("FAIL hold_pulse_width got=%h exp=0", key_press);
                end
            end
        end
        settle();
    endtask

    task automatic test_repeat();
        logic [63:0] got_p, got_r, exp_p, exp_r;
        got_p = '0; got_r = '0;
        // Release at 34 coincides with a repeat due at 34: release wins.
        exp_p = (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22)
              | (64'd1 << 25) | (64'd1 << 28) | (64'd1 << 31);
        exp_r = 64'd1 << 34;
        rpt_en = 4'b0100;
        key_in[KEY_RIGHT] = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            got_p[k] = key_press[KEY_RIGHT];
            got_r[k] = key_release[KEY_RIGHT];
            if (k == 28) key_in[KEY_RIGHT] = 1'b0;
        end
        checks++;
        if (got_p !== exp_p) begin
            failures++; $display("FAIL repeat_press got=%h exp=%h", got_p, exp_p);
        end
        checks++;
        if (got_r !== exp_r) begin
            failures++; $display("FAIL repeat_release got=%h exp=%h", got_r, exp_r);
        end
        settle();
    endtask

    task automatic test_no_repeat();
        logic [127:0] got_p, got_r, exp_p, exp_r;
        got_p = '0; got_r = '0;
        exp_p = 128'd1 << 6;
        exp_r = 128'd1 << 56;
        key_in[KEY_DOWN] = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            got_p[k] = key_press[KEY_DOWN];
            got_r[k] = key_release[KEY_DOWN];
            if (k == 50) key_in[KEY_DOWN] = 1'b0;
        end
        checks++;
        if (got_p !== exp_p) begin
            failures++; $display("FAIL norpt_press got=%h exp=%h", got_p, exp_p);
        end
        checks++;
        if (got_r !== exp_r) begin
            failures++; $display("FAIL norpt_release got=%h exp=%h", got_r, exp_r);
        end
        settle();
    endtask

    task automatic test_lock();
        logic [63:0] got_p, got_r, exp_p;
        got_p = '0; got_r = '0;
        exp_p = (64'd1 << 19) | (64'd1 << 22) | (64'd1 << 25);
        lock = 1'b1; rpt_en = 4'b0001;
        key_in[KEY_UP] = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            got_p[k] = key_press[KEY_UP];
            got_r[k] = key_release[KEY_UP];
            if (k == 6) begin
                checks++;
                if (key_level[KEY_UP] !== 1'b1) begin
                    failures++; $display("FAIL lock_level got=%b exp=1", key_level[KEY_UP]);
                end
            end
            if (k == 8) lock = 1'b0;
            if (k == 26) begin
                lock = 1'b1; key_in[KEY_UP] = 1'b0;
            end
        end
        checks++;
        if (got_p !== exp_p) begin
            failures++; $display("FAIL lock_press got=%h exp=%h", got_p, exp_p);
        end
        checks++;
        if (got_r !== '0 || key_level[KEY_UP] !== 1'b0) begin
            failures++; $display("FAIL lock_release got=%h/%b exp=0/0", got_r, key_level[KEY_UP]);
        end
        settle();
    endtask

    task automatic test_simultaneous();
        key_in = 4'b1001;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 6) begin
                checks++;
                if ({key_press, any_press} !== {4'b1001, 1'b1}) begin
                    failures++; $display("FAIL simul_press got=%b/%b exp=1001/1", key_press, any_press);
                end
            end
            if (k == 7) begin
                checks++;
                if ({key_press, any_press} !== 5'b0) begin
                    failures++; $display("FAIL simul_width got=%b/%b exp=0000/0", key_press, any_press);
                end
            end
        end
        settle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 1200; n++) begin
            @(negedge clk);
            checks++;
            if ({key_level, key_press, key_release, any_press} !== {m_lvl, m_prs, m_rel, m_any}) begin
                failures++;
                $display("FAIL random_vs_model n=%0d got=%b/%b/%b/%b exp=%b/%b/%b/%b", n,
                         key_level, key_press, key_release, any_press, m_lvl, m_prs, m_rel, m_any);
            end
            for (int i = 0; i < NK; i++)
                if ($urandom_range(0, 5 + 6 * i) == 0) key_in[i] = ~key_in[i];
            if ($urandom_range(0, 39) == 0) rpt_en = 4'($urandom);
            if ($urandom_range(0, 29) == 0) lock = ~lock;
            if (n == 600) clr = 1'b0;
            if (n == 603) clr = 1'b1;
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_repeat();
        test_no_repeat();
        test_lock();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_input_ctrl.md
Name: key_input_ctrl

Overview:
Parametrised successor to the single-purpose four-key debouncer in front of the Tetris controller. It synchronises and debounces NUM_KEYS raw button inputs and produces a debounced level, a one-cycle press pulse, and a one-cycle release pulse for each key. Each key can also generate hold-to-repeat press pulses (initial delay, then a fixed period), enabled per key. A global lock suppresses pulses while the game controller is busy (remove/shift). The block sits between board buttons and the control FSM.

Parameters:
NUM_KEYS, 4, number of independent key channels (>=1)
ACTIVE_HIGH, 1, 1: key_in high = pressed; 0: key_in low = pressed
DEB_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (>=2)
RPT_DELAY, 25000000, cycles from the initial press pulse to the first repeat pulse (>=1)
RPT_PERIOD, 5000000, cycles between subsequent repeat pulses (>=1)

Ports:
clk  input  1  system clock
clr  input  1  asynchronous reset, active low
key_in  input  NUM_KEYS  raw asynchronous buttons, bit i = key i
rpt_en  input  NUM_KEYS  per-key auto-repeat enable
lock  input  1  1 = suppress all press/release pulses
key_level  output  NUM_KEYS  debounced pressed state
key_press  output  NUM_KEYS  one-cycle pulse on accepted press and on each repeat
key_release  output  NUM_KEYS  one-cycle pulse on accepted release
any_press  output  1  OR of key_press (registered together with key_press)

Behaviour:
- Reset (clr=0, async): sync flops = released level; all counters = 0; key_level, key_press, key_release, any_press = 0.
- Sync: 2-flop synchroniser per key. Normalised s_i = synced value, inverted when ACTIVE_HIGH=0.
- Debounce, per key: counter deb_cnt, width $clog2(DEB_CYCLES+1).
  - s_i != key_level[i]: deb_cnt increments each cycle.
  - s_i == key_level[i]: deb_cnt clears.
  - Accept: on the cycle deb_cnt would reach DEB_CYCLES, key_level[i] toggles and deb_cnt clears.
  - Latency from the key_in edge to the key_level change: 2 + DEB_CYCLES cycles. A glitch shorter than DEB_CYCLES cycles produces no change.
- Pulses (all outputs registered):
  - key_press[i] = 1 in the same cycle key_level[i] rises, if lock=0.
  - key_release[i] = 1 in the same cycle key_level[i] falls, if lock=0.
  - A pulse suppressed by lock is dropped, never deferred.
- Repeat, per-key FSM with counter rpt_cnt of width $clog2(max(RPT_DELAY,RPT_PERIOD)+1):
  - States: IDLE, DELAY, REPEAT.
  - IDLE -> DELAY when key_level rises and rpt_en=1 and lock=0; rpt_cnt=0.
  - DELAY: rpt_cnt increments. At RPT_DELAY cycles after the initial pulse, emit key_press, go to REPEAT, rpt_cnt=0.
  - REPEAT: emit key_press every RPT_PERIOD cycles.
  - Any state -> IDLE when key_level falls, or rpt_en[i]=0, or lock=1.
  - IDLE -> DELAY also when key_level=1 and rpt_en=1 and lock=0 (re-enable while held). In this case there is no immediate pulse; the first pulse comes after RPT_DELAY cycles.
- Simultaneous events:
  - Channels are fully independent; several key_press bits may assert in one cycle.
  - A release accepted in the same cycle a repeat falls due: only key_release pulses.
  - rpt_en=0 with RPT_* never affects key_level, key_press on edges, or key_release.
- Lock does not affect the synchroniser, debounce, or key_level.
- Reset mid-operation: all state is lost. A key held through reset deassertion is seen as a new press 2+DEB_CYCLES cycles later, with a key_press pulse if lock=0.

Decomposition:
- Package tetris_key_pkg: key index constants KEY_UP=0, KEY_LEFT=1, KEY_RIGHT=2, KEY_DOWN=3, NUM_GAME_KEYS=4; repeat FSM state enum (IDLE, DELAY, REPEAT).
- Sub-module key_chan: one channel (sync, debounce, repeat FSM). The top level instantiates NUM_KEYS copies in a generate loop and forms any_press.

Test Plan:
(Bench overrides: NUM_KEYS=4, DEB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3, ACTIVE_HIGH=1.)
1. Reset: clr=0 with key_in=4'b1111 -> all outputs 0. Release clr with keys still held -> key_level=4'b1111 and key_press=4'b1111 for one cycle, exactly 6 cycles later.
2. Glitch: key_in[1] high for 3 cycles, then low -> key_level, key_press, key_release stay 0. Held 4 or more cycles -> key_level[1]=1 at edge+6, with a one-cycle key_press[1].
3. Auto-repeat: rpt_en[2]=1, hold key 2 -> key_press[2] at accept cycle T, then at T+10, T+13, T+16. Release -> key_release[2] pulse and no further pulses.
4. rpt_en=0: hold key 3 for 50 cycles -> exactly one key_press[3] and, on release, one key_release[3].
5. Lock: lock=1 while key 0 is accepted -> key_level[0]=1, key_press[0] stays 0. Drop lock with rpt_en[0]=1 -> first key_press[0] 10 cycles later, then every 3 cycles.
6. Simultaneous: keys 0 and 3 accepted in the same cycle -> key_press=4'b1001 and any_press=1 for one cycle.
